// File: rtl/arbitro_memoria.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_memoria
// Brief    : Grants the single-port memory to the IF or MEM stage, one access
//            at a time, with a multi-cycle strobe and a one-cycle pronto pulse.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_memoria #(
    parameter int LATENCIA        = 2,
    parameter int PRIORIDADE_FIXA = 0,
    parameter int ENDERECO_MAX    = 1500
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqIF,
    input  logic [31:0] endIF,
    output logic [31:0] dadoIF,
    output logic        prontoIF,
    input  logic        reqMEM,
    input  logic        wrMEM,
    input  logic [31:0] endMEM,
    input  logic [31:0] valorMEM,
    output logic [31:0] dadoMEM,
    output logic        prontoMEM,
    output logic        erroEndereco,
    output logic [31:0] memEndereco,
    output logic [31:0] memValor,
    output logic        escreverMemoria,
    output logic        lerMemoria,
    input  logic [31:0] memSaida,
    output logic        ocupado
);
    localparam int                 c_cnt_w   = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_ini = c_cnt_w'(LATENCIA - 1);
    localparam logic               c_id_if   = 1'b0;
    localparam logic               c_id_mem  = 1'b1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESSO  = 2'd1,
        CONCLUI = 2'd2
    } estado_t;

    estado_t            estado_q,   estado_d;
    logic [c_cnt_w-1:0] contador_q, contador_d;
    logic               ultimo_q,   ultimo_d;
    logic               id_q,       id_d;
    logic               ler_q,      ler_d;
    logic               esc_q,      esc_d;
    logic [31:0]        mem_end_q,  mem_end_d;
    logic [31:0]        mem_val_q,  mem_val_d;
    logic               pronto_if_q,  pronto_if_d;
    logic               pronto_mem_q, pronto_mem_d;
    logic               erro_q,     erro_d;
    logic [31:0]        dado_if_q,  dado_if_d;
    logic [31:0]        dado_mem_q, dado_mem_d;
    logic               ocupado_q,  ocupado_d;

    logic               w_any_req;
    logic               w_grant_mem;
    logic               w_wr_sel;
    logic               w_fora;
    logic [31:0]        w_end_sel;
    logic [31:0]        w_val_sel;

    // On contention MEM wins under fixed priority, or when IF was served last.
    assign w_any_req   = reqIF | reqMEM;
    assign w_grant_mem = reqMEM & (~reqIF | (PRIORIDADE_FIXA != 0) | (ultimo_q == c_id_if));
    assign w_end_sel   = w_grant_mem ? endMEM : endIF;
    assign w_wr_sel    = w_grant_mem & wrMEM;
    assign w_val_sel   = w_wr_sel ? valorMEM : 32'd0;
    assign w_fora      = (w_end_sel > 32'(ENDERECO_MAX));

    always_comb begin
        estado_d     = estado_q;
        contador_d   = contador_q;
        ultimo_d     = ultimo_q;
        id_d         = id_q;
        ler_d        = 1'b0;
        esc_d        = 1'b0;
        mem_end_d    = 32'd0;
        mem_val_d    = 32'd0;
        pronto_if_d  = 1'b0;
        pronto_mem_d = 1'b0;
        erro_d       = 1'b0;
        dado_if_d    = dado_if_q;
        dado_mem_d   = dado_mem_q;

        unique case (estado_q)
            OCIOSO: begin
                if (w_any_req) begin
                    id_d = w_grant_mem;
                    if (w_fora) begin
                        estado_d = CONCLUI;
                        ultimo_d = w_grant_mem;
                        erro_d   = 1'b1;
                        if (w_grant_mem == c_id_mem) begin
                            pronto_mem_d = 1'b1;
                            dado_mem_d   = 32'd0;
                        end else begin
                            pronto_if_d = 1'b1;
                            dado_if_d   = 32'd0;
                        end
                    end else begin
                        estado_d   = ACESSO;
                        contador_d = c_cnt_ini;
                        ler_d      = ~w_wr_sel;
                        esc_d      = w_wr_sel;
                        mem_end_d  = w_end_sel;
                        mem_val_d  = w_val_sel;
                    end
                end
            end
            ACESSO: begin
                if (contador_q == '0) begin
                    estado_d = CONCLUI;
                    ultimo_d = id_q;
                    if (id_q == c_id_mem) begin
                        pronto_mem_d = 1'b1;
                        if (!esc_q) dado_mem_d = memSaida;
                    end else begin
                        pronto_if_d = 1'b1;
                        if (!esc_q) dado_if_d = memSaida;
                    end
                end else begin
                    contador_d = contador_q - c_cnt_w'(1);
                    ler_d      = ler_q;
                    esc_d      = esc_q;
                    mem_end_d  = mem_end_q;
                    mem_val_d  = mem_val_q;
                end
            end
            CONCLUI: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        ocupado_d = (estado_d != OCIOSO);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            contador_q   <= '0;
            ultimo_q     <= c_id_if;
            id_q         <= c_id_if;
            ler_q        <= 1'b0;
            esc_q        <= 1'b0;
            mem_end_q    <= 32'd0;
            mem_val_q    <= 32'd0;
            pronto_if_q  <= 1'b0;
            pronto_mem_q <= 1'b0;
            erro_q       <= 1'b0;
            dado_if_q    <= 32'd0;
            dado_mem_q   <= 32'd0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            contador_q   <= contador_d;
            ultimo_q     <= ultimo_d;
            id_q         <= id_d;
            ler_q        <= ler_d;
            esc_q        <= esc_d;
            mem_end_q    <= mem_end_d;
            mem_val_q    <= mem_val_d;
            pronto_if_q  <= pronto_if_d;
            pronto_mem_q <= pronto_mem_d;
            erro_q       <= erro_d;
            dado_if_q    <= dado_if_d;
            dado_mem_q   <= dado_mem_d;
            ocupado_q    <= ocupado_d;
        end
    end

    assign dadoIF          = dado_if_q;
    assign prontoIF        = pronto_if_q;
    assign dadoMEM         = dado_mem_q;
    assign prontoMEM       = pronto_mem_q;
    assign erroEndereco    = erro_q;
    assign memEndereco     = mem_end_q;
    assign memValor        = mem_val_q;
    assign escreverMemoria = esc_q;
    assign lerMemoria      = ler_q;
    assign ocupado         = ocupado_q;

endmodule
`default_nettype wire
